// File: rtl/pu_or1k_spr_gpr_initiator.sv
// ---------------------------------------------------------------------------
// pu_or1k_spr_gpr_initiator
//
// SPR-bus initiator for the GPR window (SPR group 0, 0x0400-0x05FF). The
// debug / context-switch logic hands it a burst command (read or write,
// first GPR index, length minus one). The block then runs one SPR transaction
// per beat. Write data is streamed in and read data is streamed out.
//
// Optional feature: define PU_OR1K_SPR_GPR_TIMEOUT_EN to add a per-beat
// strobe timeout. When it expires, the burst is aborted and err_o is set.
// Without the macro, a beat waits for its ack forever and err_o is tied low.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   cmd_valid_i / cmd_ready_o    command handshake
//   cmd_we_i                     1 = write burst, 0 = read burst
//   cmd_index_i, cmd_count_i     first GPR index, burst length minus 1
//   wr_valid_i / wr_ready_o      write-data stream handshake
//   wr_data_i                    write data
//   rd_valid_o / rd_ready_i      read-data stream handshake
//   rd_data_o                    read data
//   done_o                       one-cycle pulse at burst end (also on abort)
//   err_o                        sticky timeout flag, cleared by next command
//   spr_bus_addr_o/stb_o/we_o/dat_o   SPR bus request
//   spr_gpr_ack_i, spr_gpr_dat_i      GPR responder ack and read data
// ---------------------------------------------------------------------------
module pu_or1k_spr_gpr_initiator #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int GPR_INDEX_WIDTH      = 9,
    parameter int TIMEOUT_CYCLES       = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid_i,
    output logic                            cmd_ready_o,
    input  logic                            cmd_we_i,
    input  logic [GPR_INDEX_WIDTH-1:0]      cmd_index_i,
    input  logic [GPR_INDEX_WIDTH-1:0]      cmd_count_i,
    input  logic                            wr_valid_i,
    output logic                            wr_ready_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wr_data_i,
    output logic                            rd_valid_o,
    input  logic                            rd_ready_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] rd_data_o,
    output logic                            done_o,
    output logic                            err_o,
    output logic [15:0]                     spr_bus_addr_o,
    output logic                            spr_bus_stb_o,
    output logic                            spr_bus_we_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_o,
    input  logic                            spr_gpr_ack_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_ACCESS,
        ST_RDATA,
        ST_GAP,
        ST_END
    } state_t;

    state_t                            r_state;
    state_t                            w_stateNext;

    logic                              r_we;
    logic [GPR_INDEX_WIDTH-1:0]        r_idx;
    logic [GPR_INDEX_WIDTH-1:0]        r_count;
    logic [GPR_INDEX_WIDTH-1:0]        r_beat;
    logic [15:0]                       r_addr;
    logic                              r_stb;
    logic                              r_busWe;
    logic [OPTION_OPERAND_WIDTH-1:0]   r_busDat;
    logic                              r_rdValid;
    logic [OPTION_OPERAND_WIDTH-1:0]   r_rdData;
    logic                              r_done;
    logic                              r_err;

    logic                              w_accept;
    logic                              w_advance;
    logic                              w_rdCapture;
    logic                              w_wrLatch;
    logic                              w_abort;
    logic                              w_lastBeat;
    logic                              w_timeoutHit;
    logic                              w_weNext;
    logic [GPR_INDEX_WIDTH-1:0]        w_idxNext;

    assign w_lastBeat = (r_beat == r_count);

    // During the accept cycle r_we still holds the previous burst's
    // direction, so the strobe qualifier must look at the incoming command.
    assign w_weNext  = w_accept ? cmd_we_i : r_we;
    assign w_idxNext = w_accept  ? cmd_index_i :
                       w_advance ? r_idx + 1'b1 : r_idx;

`ifdef PU_OR1K_SPR_GPR_TIMEOUT_EN
    // The counter needs at least 8 bits, or more if TIMEOUT_CYCLES needs them.
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TO_W-1:0] r_toCnt;

    // Count the ACCESS cycles of the current beat. The counter is zero in
    // every other state, so it restarts each time ACCESS is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_toCnt <= '0;
        end else if (r_state == ST_ACCESS) begin
            r_toCnt <= r_toCnt + 1'b1;
        end else begin
            r_toCnt <= '0;
        end
    end

    // The limit is hit on the TIMEOUT_CYCLES-th strobe cycle without ack.
    // The strobe is therefore high for exactly TIMEOUT_CYCLES cycles.
    assign w_timeoutHit = !spr_gpr_ack_i && (r_toCnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the timeout feature, a beat never aborts.
    // This expression is constant false.
    assign w_timeoutHit = (TIMEOUT_CYCLES < 0);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic, plus the one-cycle control strobes for the datapath.
    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_advance   = 1'b0;
        w_rdCapture = 1'b0;
        w_wrLatch   = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    w_accept    = 1'b1;
                    w_stateNext = cmd_we_i ? ST_WDATA : ST_ACCESS;
                end
            end
            ST_WDATA: begin
                if (wr_valid_i) begin
                    w_wrLatch   = 1'b1;
                    w_stateNext = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (spr_gpr_ack_i) begin
                    if (!r_we) begin
                        w_rdCapture = 1'b1;
                        w_stateNext = ST_RDATA;
                    end else if (w_lastBeat) begin
                        w_stateNext = ST_END;
                    end else begin
                        w_advance   = 1'b1;
                        w_stateNext = ST_WDATA;
                    end
                end else if (w_timeoutHit) begin
                    w_abort     = 1'b1;
                    w_stateNext = ST_END;
                end
            end
            ST_RDATA: begin
                if (rd_ready_i) begin
                    if (w_lastBeat) begin
                        w_stateNext = ST_END;
                    end else begin
                        w_advance   = 1'b1;
                        w_stateNext = ST_GAP;
                    end
                end
            end
            // One idle strobe cycle between read beats. The responder
            // registers its read ack, so back-to-back strobes would return
            // stale data.
            ST_GAP: begin
                w_stateNext = ST_ACCESS;
            end
            ST_END: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Burst bookkeeping: direction, index, beat counter and length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_count <= '0;
            r_beat  <= '0;
            r_addr  <= '0;
        end else begin
            r_we  <= w_weNext;
            r_idx <= w_idxNext;
            if (w_accept || w_advance) begin
                r_addr <= {7'h02, w_idxNext};
            end
            if (w_accept) begin
                r_count <= cmd_count_i;
                r_beat  <= '0;
            end else if (w_advance) begin
                r_beat <= r_beat + 1'b1;
            end
        end
    end

    // Registered bus and stream outputs. Each output is computed from the
    // next state, so it lines up with the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stb     <= 1'b0;
            r_busWe   <= 1'b0;
            r_busDat  <= '0;
            r_rdValid <= 1'b0;
            r_rdData  <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_stb     <= (w_stateNext == ST_ACCESS);
            r_busWe   <= (w_stateNext == ST_ACCESS) && w_weNext;
            r_rdValid <= (w_stateNext == ST_RDATA);
            r_done    <= (w_stateNext == ST_END);
            if (w_wrLatch) begin
                r_busDat <= wr_data_i;
            end
            if (w_rdCapture) begin
                r_rdData <= spr_gpr_dat_i;
            end
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_abort) begin
                r_err <= 1'b1;
            end
        end
    end

    assign cmd_ready_o    = (r_state == ST_IDLE);
    assign wr_ready_o     = (r_state == ST_WDATA);
    assign rd_valid_o     = r_rdValid;
    assign rd_data_o      = r_rdData;
    assign done_o         = r_done;
`ifdef PU_OR1K_SPR_GPR_TIMEOUT_EN
    assign err_o          = r_err;
`else
    assign err_o          = 1'b0;
`endif
    assign spr_bus_addr_o = r_addr;
    assign spr_bus_stb_o  = r_stb;
    assign spr_bus_we_o   = r_busWe;
    assign spr_bus_dat_o  = r_busDat;

`ifndef PU_OR1K_SPR_GPR_TIMEOUT_EN
    // err_o is tied low in this build, so the flag register is unobserved.
    logic w_errUnused;
    assign w_errUnused = r_err;
`endif

endmodule

// File: tb/tb_pu_or1k_spr_gpr_initiator.sv
// ---------------------------------------------------------------------------
// tb_pu_or1k_spr_gpr_initiator
//
// Drives pu_or1k_spr_gpr_initiator against a small GPR responder model.
// The responder is a 512-word memory. Its combinational ack fires after a
// programmable number of strobe cycles. Expected bus beats and expected read
// words go into queues when a command is issued. A negedge monitor pops and
// compares those queues as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_pu_or1k_spr_gpr_initiator;

    localparam int W = 32;
`ifdef PU_OR1K_SPR_GPR_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [8:0]    cmd_index_i, cmd_count_i;
    logic          wr_valid_i, wr_ready_o;
    logic [W-1:0]  wr_data_i;
    logic          rd_valid_o, rd_ready_i;
    logic [W-1:0]  rd_data_o;
    logic          done_o, err_o;
    logic [15:0]   spr_bus_addr_o;
    logic          spr_bus_stb_o, spr_bus_we_o;
    logic [W-1:0]  spr_bus_dat_o;
    logic          spr_gpr_ack_i;
    logic [W-1:0]  spr_gpr_dat_i;

    always #5 clk = ~clk;

    pu_or1k_spr_gpr_initiator #(
        .OPTION_OPERAND_WIDTH(W),
        .GPR_INDEX_WIDTH(9),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_we_i(cmd_we_i),
        .cmd_index_i(cmd_index_i),
        .cmd_count_i(cmd_count_i),
        .wr_valid_i(wr_valid_i),
        .wr_ready_o(wr_ready_o),
        .wr_data_i(wr_data_i),
        .rd_valid_o(rd_valid_o),
        .rd_ready_i(rd_ready_i),
        .rd_data_o(rd_data_o),
        .done_o(done_o),
        .err_o(err_o),
        .spr_bus_addr_o(spr_bus_addr_o),
        .spr_bus_stb_o(spr_bus_stb_o),
        .spr_bus_we_o(spr_bus_we_o),
        .spr_bus_dat_o(spr_bus_dat_o),
        .spr_gpr_ack_i(spr_gpr_ack_i),
        .spr_gpr_dat_i(spr_gpr_dat_i)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [31:0] dat;
    } beat_t;

    beat_t       beatQ[$];
    logic [31:0] rdQ[$];
    logic [31:0] gprMem [512];
    logic [31:0] expMem [512];

    int   errCount   = 0;
    int   checkCount = 0;

    logic ackEn;
    int   ackDelay;
    int   stbCnt;

    int   doneCount    = 0;
    int   stbRun       = 0;
    int   lastStbRun   = 0;
    int   rdValidCycles = 0;
    logic prevStb, prevAck, prevRdValid, prevRdReady, prevWe;
    logic [15:0] prevAddr;
    logic [31:0] prevDat, prevRdData;

    function automatic logic [31:0] initVal(input int i);
        return {16'hC0DE, 7'h00, 9'(i)};
    endfunction

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Responder model: combinational ack after ackDelay strobe cycles.
    // Read data is returned only while ack is high. Otherwise the data bus
    // carries a garbage pattern, so an early capture shows up as a mismatch.
    assign spr_gpr_ack_i = spr_bus_stb_o && ackEn && (stbCnt >= ackDelay);
    assign spr_gpr_dat_i = spr_gpr_ack_i ? gprMem[spr_bus_addr_o[8:0]] : 32'hBAD0BAD0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stbCnt <= 0;
            for (int i = 0; i < 512; i++) gprMem[i] <= initVal(i);
        end else begin
            if (spr_bus_stb_o && !spr_gpr_ack_i) stbCnt <= stbCnt + 1;
            else                                 stbCnt <= 0;
            if (spr_bus_stb_o && spr_gpr_ack_i && spr_bus_we_o)
                gprMem[spr_bus_addr_o[8:0]] <= spr_bus_dat_o;
        end
    end

    // Bus and stream monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (rst) begin
            prevStb = 1'b0; prevAck = 1'b0; prevRdValid = 1'b0; prevRdReady = 1'b0;
            prevWe = 1'b0; prevAddr = '0; prevDat = '0; prevRdData = '0;
            stbRun = 0;
        end else begin
            if (prevAck)
                checkOutput("stbGap", 64'(spr_bus_stb_o), 64'(0));
            if (spr_bus_stb_o && prevStb && !prevAck)
                checkOutput("holdStable", 64'({spr_bus_addr_o, spr_bus_we_o, spr_bus_dat_o}),
                            64'({prevAddr, prevWe, prevDat}));
            if (rd_valid_o && prevRdValid && !prevRdReady)
                checkOutput("rdHeld", 64'(rd_data_o), 64'(prevRdData));
            if (rd_valid_o) begin
                rdValidCycles++;
                checkOutput("stbInRdata", 64'(spr_bus_stb_o), 64'(0));
            end
            if (spr_bus_stb_o && spr_gpr_ack_i) begin
                if (beatQ.size() == 0) begin
                    checkOutput("beatQueueDepth", 64'(beatQ.size()), 64'(1));
                end else begin
                    beat_t e;
                    e = beatQ.pop_front();
                    checkOutput("beatAddr", 64'(spr_bus_addr_o), 64'(e.addr));
                    checkOutput("beatWe", 64'(spr_bus_we_o), 64'(e.we));
                    if (e.we) checkOutput("beatDat", 64'(spr_bus_dat_o), 64'(e.dat));
                end
            end
            if (rd_valid_o && rd_ready_i) begin
                if (rdQ.size() == 0) begin
                    checkOutput("rdQueueDepth", 64'(rdQ.size()), 64'(1));
                end else begin
                    logic [31:0] d;
                    d = rdQ.pop_front();
                    checkOutput("rdData", 64'(rd_data_o), 64'(d));
                end
            end
            if (spr_bus_stb_o) begin
                stbRun++;
            end else if (prevStb) begin
                lastStbRun = stbRun;
                stbRun = 0;
            end
            if (done_o) doneCount++;
            prevStb     = spr_bus_stb_o;
            prevAck     = spr_bus_stb_o && spr_gpr_ack_i;
            prevRdValid = rd_valid_o;
            prevRdReady = rd_ready_i;
            prevWe      = spr_bus_we_o;
            prevAddr    = spr_bus_addr_o;
            prevDat     = spr_bus_dat_o;
            prevRdData  = rd_data_o;
        end
    end

    // Present a command and wait (bounded) until it is accepted.
    task automatic issueCommand(input logic we, input logic [8:0] idx, input logic [8:0] cnt);
        int n = 0;
        cmd_we_i    = we;
        cmd_index_i = idx;
        cmd_count_i = cnt;
        cmd_valid_i = 1'b1;
        @(negedge clk);
        while (!cmd_ready_o && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("cmdReady", 64'(cmd_ready_o), 64'(1));
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    // Run one full burst. Expected beats and read words are queued first.
    // The task then feeds write data, drives rd_ready and waits for done_o.
    task automatic applyStimulus(input logic we, input logic [8:0] idx, input logic [8:0] cnt,
                                 input int delay, input bit toggleReady, input logic [31:0] wBase);
        int  startDone;
        bit  finished;
        startDone = doneCount;
        finished  = 1'b0;
        ackEn     = 1'b1;
        ackDelay  = delay;
        for (int k = 0; k <= int'(cnt); k++) begin
            logic [8:0]  a;
            logic [31:0] d;
            a = idx + 9'(k);
            d = wBase + 32'(k);
            if (we) begin
                beatQ.push_back({7'h02, a, 1'b1, d});
                expMem[a] = d;
            end else begin
                beatQ.push_back({7'h02, a, 1'b0, 32'h0});
                rdQ.push_back(expMem[a]);
            end
        end
        issueCommand(we, idx, cnt);
        fork
            begin
                if (we) begin
                    for (int k = 0; k <= int'(cnt); k++) begin
                        int n = 0;
                        wr_valid_i = 1'b1;
                        wr_data_i  = wBase + 32'(k);
                        @(negedge clk);
                        while (!wr_ready_o && n < 2000) begin
                            @(negedge clk);
                            n++;
                        end
                        if (!wr_ready_o) begin
                            checkOutput("wrReady", 64'(wr_ready_o), 64'(1));
                            break;
                        end
                        @(posedge clk);
                        #1;
                    end
                    wr_valid_i = 1'b0;
                end
            end
            begin
                rd_ready_i = toggleReady ? 1'b0 : 1'b1;
                while (!finished) begin
                    @(posedge clk);
                    #1;
                    if (toggleReady) rd_ready_i = ~rd_ready_i;
                end
                rd_ready_i = 1'b0;
            end
            begin
                int n = 0;
                while (doneCount == startDone && n < 20000) begin
                    @(posedge clk);
                    n++;
                end
                finished = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        checkOutput("donePulses", 64'(doneCount - startDone), 64'(1));
        checkOutput("errClear", 64'(err_o), 64'(0));
        checkOutput("beatsLeft", 64'(beatQ.size()), 64'(0));
        checkOutput("rdLeft", 64'(rdQ.size()), 64'(0));
        beatQ.delete();
        rdQ.delete();
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_index_i = '0; cmd_count_i = '0;
        wr_valid_i = 1'b0; wr_data_i = '0; rd_ready_i = 1'b0;
        ackEn = 1'b1; ackDelay = 0;
        for (int i = 0; i < 512; i++) expMem[i] = initVal(i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstCmdReady", 64'(cmd_ready_o), 64'(1));
        checkOutput("rstWrReady", 64'(wr_ready_o), 64'(0));
        checkOutput("rstRdValid", 64'(rd_valid_o), 64'(0));
        checkOutput("rstRdData", 64'(rd_data_o), 64'(0));
        checkOutput("rstDone", 64'(done_o), 64'(0));
        checkOutput("rstErr", 64'(err_o), 64'(0));
        checkOutput("rstStb", 64'(spr_bus_stb_o), 64'(0));
        checkOutput("rstWe", 64'(spr_bus_we_o), 64'(0));
        checkOutput("rstAddr", 64'(spr_bus_addr_o), 64'(0));
        checkOutput("rstDat", 64'(spr_bus_dat_o), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] single write idx 3");
        applyStimulus(1'b1, 9'd3, 9'd0, 0, 1'b0, 32'hDEADBEEF);
        checkOutput("wrStbCycles", 64'(lastStbRun), 64'(1));

        $display("[TB] single read idx 5");
        applyStimulus(1'b0, 9'd5, 9'd0, 1, 1'b1, 32'h0);
        checkOutput("rdStbCycles", 64'(lastStbRun), 64'(2));

        $display("[TB] readback idx 3");
        applyStimulus(1'b0, 9'd3, 9'd0, 1, 1'b0, 32'h0);

        $display("[TB] read burst wrapping 0x1FE");
        applyStimulus(1'b0, 9'h1FE, 9'd3, 1, 1'b1, 32'h0);

        $display("[TB] write burst with held ack");
        applyStimulus(1'b1, 9'h010, 9'd3, 5, 1'b0, 32'h1000_0000);
        checkOutput("holdStbCycles", 64'(lastStbRun), 64'(6));

        $display("[TB] full-window write burst");
        applyStimulus(1'b1, 9'h100, 9'd511, 0, 1'b0, 32'hC000_0000);

        $display("[TB] readback across wrap");
        applyStimulus(1'b0, 9'h1FE, 9'd3, 2, 1'b1, 32'h0);

`ifdef PU_OR1K_SPR_GPR_TIMEOUT_EN
        begin
            int startDone;
            int startRdValid;
            int n;
            $display("[TB] timeout abort");
            startDone    = doneCount;
            startRdValid = rdValidCycles;
            ackEn        = 1'b0;
            rd_ready_i   = 1'b1;
            issueCommand(1'b0, 9'd9, 9'd2);
            n = 0;
            while (doneCount == startDone && n < 2000) begin
                @(posedge clk);
                n++;
            end
            repeat (5) @(posedge clk);
            #1;
            checkOutput("toStbCycles", 64'(lastStbRun), 64'(TO));
            checkOutput("toErr", 64'(err_o), 64'(1));
            checkOutput("toDonePulses", 64'(doneCount - startDone), 64'(1));
            checkOutput("toNoRdValid", 64'(rdValidCycles - startRdValid), 64'(0));
            checkOutput("toStbIdle", 64'(spr_bus_stb_o), 64'(0));
            rd_ready_i = 1'b0;
            issueCommand(1'b1, 9'd20, 9'd0);
            checkOutput("toErrCleared", 64'(err_o), 64'(0));
            wr_valid_i = 1'b1;
            wr_data_i  = 32'h0;
            ackEn      = 1'b1;
            ackDelay   = 0;
            beatQ.push_back({7'h02, 9'd20, 1'b1, 32'h0});
            n = 0;
            while (doneCount == startDone + 1 && n < 1000) begin
                @(posedge clk);
                n++;
            end
            wr_valid_i = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            checkOutput("toNextDone", 64'(doneCount - startDone), 64'(2));
        end
`else
        begin
            int startDone;
            $display("[TB] no-ack hold then reset");
            startDone = doneCount;
            ackEn = 1'b0;
            issueCommand(1'b0, 9'd7, 9'd0);
            repeat (2) @(posedge clk);
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                checkOutput("stbHeldNoAck", 64'(spr_bus_stb_o), 64'(1));
            end
            #2;
            rst = 1'b1;
            #1;
            checkOutput("rstMidStb", 64'(spr_bus_stb_o), 64'(0));
            checkOutput("rstMidCmdReady", 64'(cmd_ready_o), 64'(1));
            checkOutput("rstMidDone", 64'(done_o), 64'(0));
            @(posedge clk);
            #1;
            rst = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                checkOutput("postRstDone", 64'(done_o), 64'(0));
            end
            checkOutput("postRstDoneCount", 64'(doneCount - startDone), 64'(0));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pu_or1k_spr_gpr_initiator.md
Name: pu_or1k_spr_gpr_initiator

Overview:
SPR-bus initiator for the GPR window (SPR group 0, addresses 0x0400-0x05FF), used by the debug/context-switch logic to read and write GPRs. It accepts a command (read or write, start index, burst length), streams write data in or read data out, and sequences single-beat SPR transactions. Each transaction holds strobe, address, write-enable and data stable until the GPR responder acks. It sits between the debug-unit command path and the shared SPR bus.

Parameters:
OPTION_OPERAND_WIDTH, 32, data width of the SPR bus and the data streams.
GPR_INDEX_WIDTH, 9, width of the GPR index inside the 512-entry window; fixed by the address map.
TIMEOUT_CYCLES, 255, maximum strobe cycles per beat before abort; only used when the timeout feature is compiled in.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid and ready are both high
cmd_we_i  in  1  1 = write burst, 0 = read burst
cmd_index_i  in  9  first GPR index
cmd_count_i  in  9  burst length minus 1
wr_valid_i  in  1  write-data valid
wr_ready_o  out  1  write-data accepted
wr_data_i  in  OPTION_OPERAND_WIDTH  write data
rd_valid_o  out  1  read-data valid
rd_ready_i  in  1  read-data consumer ready
rd_data_o  out  OPTION_OPERAND_WIDTH  read data
done_o  out  1  one-cycle pulse at burst end, including abort
err_o  out  1  sticky timeout flag
spr_bus_addr_o  out  16  SPR address
spr_bus_stb_o  out  1  SPR strobe
spr_bus_we_o  out  1  SPR write-enable
spr_bus_dat_o  out  OPTION_OPERAND_WIDTH  SPR write data
spr_gpr_ack_i  in  1  responder ack; combinational
spr_gpr_dat_i  in  OPTION_OPERAND_WIDTH  responder read data; valid while ack is high

Behaviour:
- Reset: FSM in IDLE. cmd_ready_o=1. All other outputs are 0: wr_ready_o, rd_valid_o, rd_data_o, done_o, err_o, spr_bus_stb_o, spr_bus_we_o, spr_bus_addr_o, spr_bus_dat_o. Beat counter = 0, index register = 0. Asserting rst mid-burst aborts it immediately; no done_o pulse.
- Address: spr_bus_addr_o = {7'h02, idx}. idx increments per beat modulo 512, so 0x1FF wraps to 0x000 and the address stays in the window.
- States:
  - IDLE: cmd_ready_o=1. On accept, latch we, index and count, clear err_o, then go to WDATA (write) or ACCESS (read).
  - WDATA: wr_ready_o=1. On wr_valid_i, latch wr_data_i into spr_bus_dat_o and go to ACCESS.
  - ACCESS: stb=1, we=latched we. Address and data are held stable. On spr_gpr_ack_i:
    - Read: capture spr_gpr_dat_i into rd_data_o and go to RDATA.
    - Write, last beat: go to END.
    - Write, otherwise: increment idx and go to WDATA.
  - RDATA: stb=0, rd_valid_o=1, rd_data_o held. On rd_ready_i: go to END if last beat; otherwise increment idx and go to GAP.
  - GAP: stb=0 for one cycle, then ACCESS.
  - END: done_o=1 for one cycle, then IDLE.
- Strobe gap: stb is always low for at least 1 cycle between beats. The responder's read ack is registered, so back-to-back strobes would return stale data.
- Write ack may be delayed indefinitely while the core is writing back; hold stb. Read ack arrives no earlier than the 2nd strobe cycle.
- Last beat: beat counter == latched count. A count of 0 gives one beat; 511 gives 512 beats.
- Output behaviour: the FSM is Moore. spr_bus_* and rd_* are registered.

Optional Feature:
- Macro: PU_OR1K_SPR_GPR_TIMEOUT_EN.
- Defined: an 8-bit-or-wider counter resets on entering ACCESS and increments each ACCESS cycle without ack. When it reaches TIMEOUT_CYCLES, drop stb, set err_o=1 and go to END (done_o pulse). Remaining beats are skipped, and no rd_valid_o is produced for the aborted beat.
- Not defined: no counter; ACCESS waits forever; err_o is tied to 0.

Test Plan:
- Single write (we=1, index 3, count 0, data 0xDEADBEEF), ack 0 cycles late -> exactly one strobe cycle at addr 0x0403 with dat 0xDEADBEEF; done_o pulses; err_o=0.
- Single read of index 5; responder acks on the 2nd strobe cycle with 0x12345678 -> rd_valid_o with rd_data_o=0x12345678 held until rd_ready_i; stb is low during RDATA.
- Read burst, index 0x1FE, count 3, rd_ready_i toggled every other cycle -> addresses 0x05FE, 0x05FF, 0x0400, 0x0401 in order; stb low ≥1 cycle between beats; four data words delivered in order.
- Write burst with ack held low for 5 cycles (simulated write-back conflict) -> addr, dat and we remain stable throughout the hold; the beat completes on ack; no duplicate beat.
- Feature on, TIMEOUT_CYCLES=8, ack never asserted -> stb drops after 8 cycles; err_o=1; done_o pulses once; the next accepted command clears err_o.
- Feature off, same stimulus -> stb stays high indefinitely. Then assert rst mid-ACCESS -> stb=0 and cmd_ready_o=1 immediately, with no done_o pulse.
